// File: rtl/pwm_demod_pkg.sv
`default_nettype none
// ============================================================
// pwm_demod_pkg : shared state encoding and default sizing.
// Rev 1.0
// ============================================================
package pwm_demod_pkg;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    TRACK  = 1'b1
  } state_e;

  localparam int PERIOD_LOG2_DEF    = 8;
  localparam int TIMEOUT_FRAMES_DEF = 2;

endpackage : pwm_demod_pkg
`default_nettype wire

// File: rtl/pwm_edge_sync.sv
`default_nettype none
// ============================================================
// pwm_edge_sync : 2-flop synchronizer plus rising-edge detector.
// Rev 1.0
// ============================================================
module pwm_edge_sync
  import pwm_demod_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic s,
  output logic rise
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q, prev_d;
  logic [1:0] warm_q, warm_d;

  always_comb begin
    sync1_d = pwm_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    warm_d  = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      warm_q  <= 2'd0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      warm_q  <= warm_d;
    end
  end

  // An input already high at reset release must not look like a frame start,
  // so edges are ignored until both the pipe and the history flop hold real samples.
  assign s    = sync2_q;
  assign rise = sync2_q & ~prev_q & (warm_q == 2'd3);

endmodule : pwm_edge_sync
`default_nettype wire

// File: rtl/pwm_demod.sv
`default_nettype none
// ============================================================
// pwm_demod : recovers the duty level of a free-running PWM stream.
// Optional PWM_DEMOD_FILTER_EN: report mean of last 4 levels. Rev 1.0
// ============================================================
module pwm_demod
  import pwm_demod_pkg::*;
#(
  parameter int PERIOD_LOG2    = PERIOD_LOG2_DEF,
  parameter int TIMEOUT_FRAMES = TIMEOUT_FRAMES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pwm_in,
  output logic [PERIOD_LOG2-1:0] level_out,
  output logic                   level_valid,
  output logic                   locked,
  output logic                   sync_err
);

  localparam int P      = PERIOD_LOG2;
  localparam int MISS_W = $clog2(TIMEOUT_FRAMES + 1);
  localparam int TMR_W  = P + MISS_W;
  localparam logic [P-1:0]      POS_MAX   = '1;
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_FRAMES * (2 ** P) - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(TIMEOUT_FRAMES - 1);

  logic s, rise;

  pwm_edge_sync u_edge_sync (
    .clk    (clk),
    .reset  (reset),
    .pwm_in (pwm_in),
    .s      (s),
    .rise   (rise)
  );

  state_e            state_q, state_d;
  logic [P-1:0]      pos_q, pos_d;
  logic [P:0]        hi_cnt_q, hi_cnt_d;
  logic [P:0]        hi_sum;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              edge_seen_q, edge_seen_d;
  logic              level_valid_q, sync_err_q, sync_err_d;
  logic              lvl_stb;
  logic [P-1:0]      lvl_new;
  logic [P-1:0]      level_q, level_d;

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    hi_cnt_d    = hi_cnt_q;
    tmr_d       = tmr_q;
    miss_d      = miss_q;
    edge_seen_d = edge_seen_q;
    sync_err_d  = 1'b0;
    lvl_stb     = 1'b0;
    lvl_new     = '0;
    hi_sum      = hi_cnt_q + (P+1)'(s);
    case (state_q)
      SEARCH: begin
        pos_d       = '0;
        hi_cnt_d    = '0;
        miss_d      = '0;
        edge_seen_d = 1'b0;
        if (rise) begin
          state_d     = TRACK;
          pos_d       = P'(1);
          hi_cnt_d    = (P+1)'(1);
          edge_seen_d = 1'b1;
          tmr_d       = '0;
        end else if (tmr_q == TMR_LAST) begin
          tmr_d   = '0;
          lvl_stb = 1'b1;
          lvl_new = {P{s}};
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      TRACK: begin
        tmr_d = '0;
        if (rise && (pos_q != '0)) begin
          // Misplaced edge: drop the partial frame and realign on this sample.
          sync_err_d  = 1'b1;
          pos_d       = P'(1);
          hi_cnt_d    = (P+1)'(1);
          edge_seen_d = 1'b1;
        end else if (pos_q == POS_MAX) begin
          lvl_stb     = 1'b1;
          lvl_new     = hi_sum[P] ? POS_MAX : hi_sum[P-1:0];
          pos_d       = '0;
          hi_cnt_d    = '0;
          edge_seen_d = 1'b0;
          if (edge_seen_q) begin
            miss_d = '0;
          end else if (miss_q == MISS_LAST) begin
            state_d = SEARCH;
            miss_d  = '0;
          end else begin
            miss_d = miss_q + 1'b1;
          end
        end else begin
          pos_d    = pos_q + 1'b1;
          hi_cnt_d = hi_sum;
          if (pos_q == '0) edge_seen_d = rise;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SEARCH;
      pos_q         <= '0;
      hi_cnt_q      <= '0;
      tmr_q         <= '0;
      miss_q        <= '0;
      edge_seen_q   <= 1'b0;
      level_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      level_q       <= '0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      hi_cnt_q      <= hi_cnt_d;
      tmr_q         <= tmr_d;
      miss_q        <= miss_d;
      edge_seen_q   <= edge_seen_d;
      level_valid_q <= lvl_stb;
      sync_err_q    <= sync_err_d;
      level_q       <= level_d;
    end
  end

`ifdef PWM_DEMOD_FILTER_EN
  // hist_q[0] is the newest stored level; a SEARCH timeout restarts the history.
  logic [2:0][P-1:0] hist_q, hist_d;
  logic [P+1:0]      sum;

  always_comb begin
    hist_d  = hist_q;
    level_d = level_q;
    sum     = '0;
    if (lvl_stb) begin
      if (state_q == SEARCH) begin
        sum    = {2'b00, lvl_new};
        hist_d = {{(2*P){1'b0}}, lvl_new};
      end else begin
        sum    = {2'b00, hist_q[0]} + {2'b00, hist_q[1]} + {2'b00, hist_q[2]} + {2'b00, lvl_new};
        hist_d = {hist_q[1:0], lvl_new};
      end
      level_d = P'(sum >> 2);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) hist_q <= '0;
    else       hist_q <= hist_d;
  end
`else
  always_comb begin
    level_d = lvl_stb ? lvl_new : level_q;
  end
`endif

  assign level_out   = level_q;
  assign level_valid = level_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == TRACK);

endmodule : pwm_demod
`default_nettype wire

// File: tb/tb_pwm_demod.sv
`default_nettype none
// ============================================================
// tb_pwm_demod : scoreboard bench for pwm_demod with a frame-level model.
// Rev 1.0
// ============================================================
module tb_pwm_demod;

  localparam int P  = 8;
  localparam int N  = 256;
  localparam int TF = 2;
`ifdef PWM_DEMOD_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pwm_in = 1'b0;
  logic [P-1:0] level_out;
  logic         level_valid, locked, sync_err;

  always #5 clk = ~clk;

  pwm_demod #(.PERIOD_LOG2(P), .TIMEOUT_FRAMES(TF)) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .level_out   (level_out),
    .level_valid (level_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  typedef struct {
    int lvl;
    int edge_n;
    bit lck;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];
  int   edge_cnt = 0;
  bit   rst_at_edge = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  // frame-level model state
  bit m_locked = 1'b0;
  int m_miss = 0;
  bit m_prev_high = 1'b0;
  bit m_shift = 1'b0;
  int m_search_start = 0;
  int hist[4] = '{default: 0};

  always @(posedge clk) begin
    edge_cnt    <= edge_cnt + 1;
    rst_at_edge <= reset;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int   t;
    if (rst_at_edge) begin
      check("reset_outputs", int'({level_out, level_valid, locked, sync_err}), 0);
    end else begin
      if (level_valid === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected_level_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("level", int'(level_out), e.lvl);
          check("level_time", edge_cnt, e.edge_n);
          check("locked_at_report", int'(locked), int'(e.lck));
        end
      end
      if (sync_err === 1'b1) begin
        if (err_q.size() == 0) check("unexpected_sync_err", 1, 0);
        else begin
          t = err_q.pop_front();
          check("sync_err_time", edge_cnt, t);
        end
      end
    end
  end

  task automatic push_level(input int lvl, input int edge_n, input bit lck, input bit clr);
    exp_t e;
    int   v;
    v = lvl;
    if (clr) hist = '{default: 0};
    hist = '{lvl, hist[0], hist[1], hist[2]};
    if (FILT) v = (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
    e.lvl = v;
    e.edge_n = edge_n;
    e.lck = lck;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic b);
    @(posedge clk);
    #1 pwm_in = b;
  endtask

  task automatic model_reset(input bit v);
    m_search_start = edge_cnt;
    m_locked = 1'b0;
    m_miss = 0;
    m_prev_high = v;
    m_shift = 1'b0;
    hist = '{default: 0};
  endtask

  task automatic do_reset(input int cycles, input logic v);
    @(posedge clk);
    #1 reset = 1'b1;
    pwm_in = v;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
    model_reset(v);
  endtask

  // One frame: high for lvl cycles from frame start (lvl = N means constant high).
  task automatic drive_frame(input int lvl);
    bit edge0, was_locked;
    int last_k, sat;
    edge0 = (lvl >= 1) && !m_prev_high;
    was_locked = m_locked;
    sat = (lvl > N - 1) ? N - 1 : lvl;
    for (int p = 0; p < N; p++) begin
      step(p < lvl);
      if (p == 0 && m_shift) begin
        err_q.push_back(edge_cnt + 3);
        m_shift = 1'b0;
      end
      if (!was_locked && edge0 && p == 2) check("not_locked_before_edge", int'(locked), 0);
      if (!was_locked && edge0 && p == 3) check("locked_after_edge", int'(locked), 1);
    end
    last_k = edge_cnt;
    m_prev_high = (lvl >= N);
    if (!m_locked) begin
      if (edge0) begin
        m_locked = 1'b1;
        m_miss = 0;
        push_level(sat, last_k + 3, 1'b1, 1'b0);
      end
    end else begin
      if (edge0) m_miss = 0;
      else m_miss++;
      if (m_miss == TF) begin
        m_locked = 1'b0;
        m_miss = 0;
        m_search_start = last_k + 3;
      end
      push_level(sat, last_k + 3, m_locked, 1'b0);
    end
  endtask

  task automatic drive_partial(input int lvl, input int len);
    for (int p = 0; p < len; p++) step(p < lvl);
    m_prev_high = (len - 1 < lvl);
    m_shift = 1'b1;
  endtask

  task automatic drive_const(input logic b, input int cycles);
    int t0, t;
    t0 = edge_cnt;
    if (!m_locked) begin
      t = m_search_start + TF * N;
      while (t <= t0 + cycles) begin
        push_level(b ? N - 1 : 0, t, 1'b0, 1'b1);
        m_search_start = t;
        t += TF * N;
      end
    end
    repeat (cycles) step(b);
    m_prev_high = b;
  endtask

  task automatic drain();
    drive_const(1'b0, 8);
    check("drain_levels", exp_q.size(), 0);
    check("drain_sync_err", err_q.size(), 0);
    exp_q.delete();
    err_q.delete();
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_cnt);
    $fatal(1);
  end

  initial begin : stimulus
    int lvl;
    // steady 0x40
    do_reset(4, 1'b0);
    drive_const(1'b0, 8);
    repeat (6) drive_frame(8'h40);
    drain();

    // short level sequence with boundary values
    do_reset(3, 1'b0);
    drive_const(1'b0, 6);
    drive_frame(8'h01);
    drive_frame(8'h80);
    drive_frame(8'hFF);
    drain();

    // idle low / idle high from reset: SEARCH timeout reports
    do_reset(3, 1'b0);
    drive_const(1'b0, 600);
    drain();
    do_reset(3, 1'b1);
    drive_const(1'b1, 600);
    drain();

    // phase jump: extra rising edge at frame position 100
    do_reset(3, 1'b0);
    drive_const(1'b0, 5);
    repeat (3) drive_frame(8'h40);
    drive_partial(8'h40, 100);
    repeat (3) drive_frame(8'h40);
    drain();

    // reset pulsed at frame position 50
    do_reset(3, 1'b0);
    drive_const(1'b0, 5);
    repeat (2) drive_frame(8'h40);
    drive_partial(8'h40, 50);
    m_shift = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    pwm_in = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    pwm_in = 1'b1;
    model_reset(1'b0);
    for (int p = 52; p < N; p++) step(p < 8'h40);
    repeat (3) drive_frame(8'h40);
    drain();

    // lock, then constant high: saturates, loses lock, then SEARCH reports
    do_reset(3, 1'b0);
    drive_const(1'b0, 5);
    drive_frame(8'h40);
    repeat (3) drive_frame(N);
    drive_const(1'b1, 600);
    drain();

    // alternating levels
    do_reset(3, 1'b0);
    drive_const(1'b0, 5);
    repeat (4) begin
      drive_frame(8'h40);
      drive_frame(8'h80);
    end
    drain();

    // randomized frames including empty and all-high frames
    do_reset(3, 1'b0);
    drive_const(1'b0, 5);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 15))
        0:       lvl = 0;
        1:       lvl = N;
        2:       lvl = N - 1;
        3:       lvl = 1;
        default: lvl = $urandom_range(1, N - 2);
      endcase
      if (!m_locked || m_miss == TF - 1) lvl = $urandom_range(1, N - 1);
      drive_frame(lvl);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pwm_demod
`default_nettype wire

// File: doc/pwm_demod.md
PWM_DEMOD -- requirements
Module: pwm_demod

Interface
REQ-001 The module SHALL have parameter PERIOD_LOG2, default 8, giving PWM frame length 2**PERIOD_LOG2 clk cycles and level width PERIOD_LOG2.
REQ-002 The module SHALL have parameter TIMEOUT_FRAMES, default 2, giving frames without a rising edge before a constant level is reported.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  reset; synchronous, active-high.
REQ-005 pwm_in  input  1  PWM bit stream, asynchronous to clk; high for level cycles from frame start.
REQ-006 level_out  output  PERIOD_LOG2  recovered duty level.
REQ-007 level_valid  output  1  one-cycle strobe; level_out updated in the same cycle.
REQ-008 locked  output  1  high while frame alignment is held.
REQ-009 sync_err  output  1  one-cycle strobe on a rising edge at a nonzero frame position while locked.

Function
REQ-010 pwm_in SHALL pass a 2-flop synchronizer, then a rising-edge detector; all counting SHALL use the synchronized sample s.
REQ-011 The FSM SHALL have states SEARCH and TRACK.
REQ-012 SEARCH: pos counter held at 0; on a rising edge of s go to TRACK, with that sample as position 0 counted as high.
REQ-013 TRACK: pos SHALL increment per cycle, modulo 2**PERIOD_LOG2; hi_cnt (PERIOD_LOG2+1 bits) SHALL add 1 per high sample.
REQ-014 At pos = max: level_out = min(hi_cnt incl. current sample, 2**PERIOD_LOG2-1); level_valid pulses the next cycle; hi_cnt restarts at the next frame.
REQ-015 A rising edge at pos = 0 SHALL be normal; at pos != 0 SHALL pulse sync_err, discard the partial frame (no level_valid), and restart the frame with that sample as position 0; state stays TRACK.
REQ-016 In TRACK, a frame with no rising edge at pos 0 SHALL still report its count; after TIMEOUT_FRAMES consecutive such frames the FSM returns to SEARCH.
REQ-017 In SEARCH, after TIMEOUT_FRAMES*2**PERIOD_LOG2 cycles without a rising edge, level_out SHALL be 0 if s is low or 2**PERIOD_LOG2-1 if high, with level_valid pulsed; the timeout then restarts.
REQ-018 locked SHALL equal (state == TRACK).
REQ-019 Latency pwm_in to counted sample SHALL be exactly 2 cycles (synchronizer); final frame sample to level_valid SHALL be 1 cycle.
REQ-020 A level of 255 (one low cycle per frame) SHALL decode as 255; the saturation SHALL apply only to constant-high input.

Reset
REQ-021 While reset is high: state = SEARCH, synchronizer flops, pos, hi_cnt and timeout counter = 0, level_out = 0, level_valid = 0, locked = 0, sync_err = 0.
REQ-022 Reset asserted mid-frame SHALL discard the frame with no level_valid; the first rising edge after release starts a frame.

Configuration
REQ-023 Macro PWM_DEMOD_FILTER_EN defined: level_out SHALL be the mean (sum >> 2, truncating) of the last 4 decoded levels, the history cleared to 0 by reset and SEARCH timeout, and level_valid timing unchanged.
REQ-024 Macro undefined: level_out SHALL be the raw per-frame level with no filter storage.

Structure
REQ-025 Package pwm_demod_pkg SHALL hold the state enum (SEARCH, TRACK) and default constants PERIOD_LOG2_DEF = 8 and TIMEOUT_FRAMES_DEF = 2.
REQ-026 Sub-module pwm_edge_sync SHALL contain the 2-flop synchronizer and the rising-edge detector; its outputs are s and rise.

Verification
REQ-027 Reset, then PWM with level 0x40 (64 high / 192 low, 256-cycle frame) -> locked = 1 after the first edge; every frame gives level_out = 0x40 with one level_valid pulse per 256 cycles.
REQ-028 Level sequence 0x01, 0x80, 0xFF, one frame each -> level_out = 0x01, 0x80, 0xFF in order, with level_valid 1 cycle after each frame end.
REQ-029 pwm_in held low 600 cycles from reset -> locked = 0, level_out = 0x00 with level_valid at cycle 512 after the synchronized input.
REQ-030 Lock at 0x40, then inject an extra rising edge at frame position 100 -> sync_err pulses once, no level_valid for the broken frame, and the next full frame reports the correct count.
REQ-031 Reset pulsed at frame position 50 -> all outputs 0 the cycle after; decoding resumes correctly from the next rising edge.
REQ-032 With PWM_DEMOD_FILTER_EN, levels 0x40 then 0x80 repeating -> level_out = 0x10, 0x30, 0x40, 0x60, then steady 0x60.
